// File: rtl/mod5_stream_arbiter_if.sv
// Handshake bundle for mod5_stream_arbiter: two word requesters plus the result port.
// master = host/consumer side, slave = the arbiter.
interface mod5_stream_arbiter_if #(
    parameter int WORD_W = 8
);
    logic              req0_valid;
    logic [WORD_W-1:0] req0_data;
    logic              req0_last;
    logic              req0_ready;

    logic              req1_valid;
    logic [WORD_W-1:0] req1_data;
    logic              req1_last;
    logic              req1_ready;

    logic              res_valid;
    logic              res_id;
    logic [2:0]        res_residue;
    logic              res_divisible;
    logic              res_abort;
    logic              busy;

    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  res_valid, res_id, res_residue, res_divisible, res_abort, busy
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output res_valid, res_id, res_residue, res_divisible, res_abort, busy
    );
endinterface

// File: rtl/mod5_stream_arbiter.sv
// Round-robin frame arbiter feeding one serial (2r+b) mod 5 residue engine.
// Define MOD5_ARB_TIMEOUT_EN to abort frames whose owner stalls too long in WAIT.
module mod5_stream_arbiter #(
    parameter int WORD_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mod5_stream_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DONE} state_e;

    localparam logic [4:0] LAST_BIT = 5'(WORD_W - 1);

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [2:0]        res_q, res_d;
    logic [4:0]        bit_q, bit_d;

    logic              res_valid_q, res_valid_d;
    logic              res_id_q, res_id_d;
    logic [2:0]        res_residue_q, res_residue_d;
    logic              res_div_q, res_div_d;

`ifdef MOD5_ARB_TIMEOUT_EN
    logic [7:0]        tmo_q, tmo_d;
    logic              res_abort_q, res_abort_d;
`else
    logic              unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
`endif

    logic              rdy0, rdy1, grant0, grant1, accept;
    logic [WORD_W-1:0] acc_data;
    logic              acc_last;
    logic [2:0]        res_step;

    // One residue recurrence step: r' = (2r + b) mod 5, r in 0..4.
    function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
        case ({r, b})
            4'b0000: mod5_step = 3'd0;
            4'b0001: mod5_step = 3'd1;
            4'b0010: mod5_step = 3'd2;
            4'b0011: mod5_step = 3'd3;
            4'b0100: mod5_step = 3'd4;
            4'b0101: mod5_step = 3'd0;
            4'b0110: mod5_step = 3'd1;
            4'b0111: mod5_step = 3'd2;
            4'b1000: mod5_step = 3'd3;
            4'b1001: mod5_step = 3'd4;
            default: mod5_step = 3'd0;
        endcase
    endfunction

    assign res_step = mod5_step(res_q, sreg_q[WORD_W-1]);

    // Readies are gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !ptr_q);
        grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr_q);
        rdy0   = 1'b0;
        rdy1   = 1'b0;
        case (state_q)
            IDLE: begin
                rdy0 = grant0;
                rdy1 = grant1;
            end
            WAIT: begin
                rdy0 = !owner_q;
                rdy1 =  owner_q;
            end
            default: ;
        endcase
        rdy0     = rdy0 && rst_n;
        rdy1     = rdy1 && rst_n;
        accept   = (rdy0 && bus.req0_valid) || (rdy1 && bus.req1_valid);
        acc_data = rdy1 ? bus.req1_data : bus.req0_data;
        acc_last = rdy1 ? bus.req1_last : bus.req0_last;
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        last_d        = last_q;
        sreg_d        = sreg_q;
        res_d         = res_q;
        bit_d         = bit_q;
        res_valid_d   = 1'b0;
        res_id_d      = res_id_q;
        res_residue_d = res_residue_q;
        res_div_d     = res_div_q;
`ifdef MOD5_ARB_TIMEOUT_EN
        tmo_d         = tmo_q;
        res_abort_d   = res_abort_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = acc_data;
                    res_d   = 3'd0;
                    owner_d = rdy1;
                    last_d  = acc_last;
                    bit_d   = 5'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d  = res_step;
                sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
                bit_d  = bit_q + 5'd1;
                if (bit_q == LAST_BIT) begin
                    bit_d = 5'd0;
                    if (last_q) begin
                        // Result registers load on the way into DONE so they are valid during it.
                        state_d       = DONE;
                        res_valid_d   = 1'b1;
                        res_id_d      = owner_q;
                        res_residue_d = res_step;
                        res_div_d     = (res_step == 3'd0);
`ifdef MOD5_ARB_TIMEOUT_EN
                        res_abort_d   = 1'b0;
`endif
                    end else begin
                        state_d = WAIT;
`ifdef MOD5_ARB_TIMEOUT_EN
                        tmo_d   = 8'd0;
`endif
                    end
                end
            end
            WAIT: begin
                if (accept) begin
                    sreg_d  = acc_data;
                    last_d  = acc_last;
                    bit_d   = 5'd0;
                    state_d = SHIFT;
                end
`ifdef MOD5_ARB_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_d == 8'(TIMEOUT)) begin
                        state_d       = DONE;
                        res_valid_d   = 1'b1;
                        res_id_d      = owner_q;
                        res_residue_d = res_q;
                        res_div_d     = (res_q == 3'd0);
                        res_abort_d   = 1'b1;
                    end
                end
`endif
            end
            DONE: begin
                ptr_d   = !owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= 1'b0;
            owner_q       <= 1'b0;
            last_q        <= 1'b0;
            sreg_q        <= '0;
            res_q         <= 3'd0;
            bit_q         <= 5'd0;
            res_valid_q   <= 1'b0;
            res_id_q      <= 1'b0;
            res_residue_q <= 3'd0;
            res_div_q     <= 1'b0;
`ifdef MOD5_ARB_TIMEOUT_EN
            tmo_q         <= 8'd0;
            res_abort_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            sreg_q        <= sreg_d;
            res_q         <= res_d;
            bit_q         <= bit_d;
            res_valid_q   <= res_valid_d;
            res_id_q      <= res_id_d;
            res_residue_q <= res_residue_d;
            res_div_q     <= res_div_d;
`ifdef MOD5_ARB_TIMEOUT_EN
            tmo_q         <= tmo_d;
            res_abort_q   <= res_abort_d;
`endif
        end
    end

    assign bus.req0_ready    = rdy0;
    assign bus.req1_ready    = rdy1;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_id        = res_id_q;
    assign bus.res_residue   = res_residue_q;
    assign bus.res_divisible = res_div_q;
    assign bus.busy          = (state_q != IDLE);
`ifdef MOD5_ARB_TIMEOUT_EN
    assign bus.res_abort     = res_abort_q;
`else
    assign bus.res_abort     = 1'b0;
`endif
endmodule

// File: tb/tb_mod5_stream_arbiter.sv
// Directed bench for mod5_stream_arbiter; the timeout scenario runs only with MOD5_ARB_TIMEOUT_EN.
module tb_mod5_stream_arbiter;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mod5_stream_arbiter_if #(.WORD_W(W)) bus ();

    mod5_stream_arbiter #(.WORD_W(W), .TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] all_outs();
        return {bus.res_valid, bus.res_id, bus.res_residue, bus.res_divisible,
                bus.res_abort, bus.busy, bus.req0_ready, bus.req1_ready};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 8'h55; bus.req0_last = 1'b1;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
        #2;
        checks++;
        if (all_outs() !== 10'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 000", all_outs());
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus.req0_valid = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 10'd0) begin
            errors++; $display("FAIL reset_idle: got %h expected 000", all_outs());
        end
    endtask

    // Single-word frame from one requester, checked cycle by cycle.
    task automatic test_single(input bit id, input logic [7:0] w, input logic [2:0] er, input string nm);
        tick();
        if (id) begin bus.req1_valid = 1'b1; bus.req1_data = w; bus.req1_last = 1'b1; end
        else    begin bus.req0_valid = 1'b1; bus.req0_data = w; bus.req0_last = 1'b1; end
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== (id ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL %s grant: got %b expected %b", nm, {bus.req0_ready, bus.req1_ready}, (id ? 2'b01 : 2'b10));
        end
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_data = ~w; bus.req1_data = ~w;
        for (int k = 0; k < W; k++) begin
            #1;
            checks++;
            if ({bus.busy, bus.res_valid, bus.req0_ready, bus.req1_ready} !== 4'b1000) begin
                errors++; $display("FAIL %s shift%0d: got %b expected 1000", nm, k,
                                   {bus.busy, bus.res_valid, bus.req0_ready, bus.req1_ready});
            end
            tick();
        end
        #1;
        checks++;
        if ({bus.res_valid, bus.res_id, bus.res_residue, bus.res_divisible, bus.res_abort, bus.busy}
            !== {1'b1, id, er, (er == 3'd0), 1'b0, 1'b1}) begin
            errors++; $display("FAIL %s result: got v%b id%b r%0d d%b a%b busy%b expected v1 id%b r%0d d%b a0 busy1", nm,
                               bus.res_valid, bus.res_id, bus.res_residue, bus.res_divisible, bus.res_abort, bus.busy,
                               id, er, (er == 3'd0));
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.busy, bus.res_id, bus.res_residue} !== {1'b0, 1'b0, id, er}) begin
            errors++; $display("FAIL %s after: got v%b busy%b id%b r%0d expected v0 busy0 id%b r%0d (held)", nm,
                               bus.res_valid, bus.busy, bus.res_id, bus.res_residue, id, er);
        end
    endtask

    // 0x01,0x00 = 256 -> residue 1; req1 waits valid throughout and is only granted after DONE.
    task automatic test_two_word();
        tick();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h01; bus.req0_last = 1'b0;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            errors++; $display("FAIL two_word grant: got %b expected 10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h09; bus.req1_last = 1'b1;
        for (int k = 0; k < W; k++) begin
            #1;
            checks++;
            if ({bus.busy, bus.req0_ready, bus.req1_ready} !== 3'b100) begin
                errors++; $display("FAIL two_word shift1_%0d: got %b expected 100", k, {bus.busy, bus.req0_ready, bus.req1_ready});
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({bus.busy, bus.res_valid, bus.req0_ready, bus.req1_ready} !== 4'b1010) begin
                errors++; $display("FAIL two_word wait%0d: got %b expected 1010", k,
                                   {bus.busy, bus.res_valid, bus.req0_ready, bus.req1_ready});
            end
            tick();
        end
        bus.req0_valid = 1'b1; bus.req0_data = 8'h00; bus.req0_last = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            errors++; $display("FAIL two_word wait_accept: got %b expected 10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        bus.req0_valid = 1'b0; bus.req0_data = 8'hFF;
        for (int k = 0; k < W; k++) begin
            #1;
            checks++;
            if ({bus.busy, bus.res_valid, bus.req0_ready, bus.req1_ready} !== 4'b1000) begin
                errors++; $display("FAIL two_word shift2_%0d: got %b expected 1000", k,
                                   {bus.busy, bus.res_valid, bus.req0_ready, bus.req1_ready});
            end
            tick();
        end
        #1;
        checks++;
        if ({bus.res_valid, bus.res_id, bus.res_residue, bus.res_divisible, bus.req1_ready} !== {1'b1, 1'b0, 3'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL two_word result: got v%b id%b r%0d d%b rdy1%b expected v1 id0 r1 d0 rdy1 0",
                               bus.res_valid, bus.res_id, bus.res_residue, bus.res_divisible, bus.req1_ready);
        end
        tick();
        checks++;
        if ({bus.busy, bus.req0_ready, bus.req1_ready} !== 3'b001) begin
            errors++; $display("FAIL two_word idle_grant: got %b expected 001", {bus.busy, bus.req0_ready, bus.req1_ready});
        end
        bus.req1_valid = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.res_valid} !== 2'b00) begin
            errors++; $display("FAIL two_word idle: got %b expected 00", {bus.busy, bus.res_valid});
        end
    endtask

    // Both valid from reset: req0 (0x05 -> 0) first, then req1 (0x03 -> 3).
    task automatic test_back_to_back();
        tick();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 8'h05; bus.req0_last = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h03; bus.req1_last = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            errors++; $display("FAIL b2b first_grant: got %b expected 10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        for (int k = 0; k < W; k++) begin
            #1;
            checks++;
            if ({bus.busy, bus.req1_ready} !== 2'b10) begin
                errors++; $display("FAIL b2b own0_%0d: got busy%b rdy1 %b expected busy1 rdy1 0", k, bus.busy, bus.req1_ready);
            end
            tick();
        end
        #1;
        checks++;
        if ({bus.res_valid, bus.res_id, bus.res_residue, bus.res_divisible, bus.req0_ready, bus.req1_ready}
            !== {1'b1, 1'b0, 3'd0, 1'b1, 2'b00}) begin
            errors++; $display("FAIL b2b result0: got v%b id%b r%0d d%b rdy%b%b expected v1 id0 r0 d1 rdy00",
                               bus.res_valid, bus.res_id, bus.res_residue, bus.res_divisible, bus.req0_ready, bus.req1_ready);
        end
        tick();
        checks++;
        if ({bus.busy, bus.req0_ready, bus.req1_ready} !== 3'b001) begin
            errors++; $display("FAIL b2b rr_grant: got %b expected 001", {bus.busy, bus.req0_ready, bus.req1_ready});
        end
        tick();
        for (int k = 0; k < W; k++) begin
            #1;
            checks++;
            if ({bus.busy, bus.req0_ready} !== 2'b10) begin
                errors++; $display("FAIL b2b own1_%0d: got busy%b rdy0 %b expected busy1 rdy0 0", k, bus.busy, bus.req0_ready);
            end
            tick();
        end
        #1;
        checks++;
        if ({bus.res_valid, bus.res_id, bus.res_residue, bus.res_divisible} !== {1'b1, 1'b1, 3'd3, 1'b0}) begin
            errors++; $display("FAIL b2b result1: got v%b id%b r%0d d%b expected v1 id1 r3 d0",
                               bus.res_valid, bus.res_id, bus.res_residue, bus.res_divisible);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.res_valid} !== 2'b00) begin
            errors++; $display("FAIL b2b idle: got %b expected 00", {bus.busy, bus.res_valid});
        end
    endtask

    // Reset in the middle of req0's 0xFF frame, then req1 0x0F -> residue 0.
    task automatic test_reset_mid_frame();
        tick();
        bus.req0_valid = 1'b1; bus.req0_data = 8'hFF; bus.req0_last = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL midrst in_shift: got busy %b expected 1", bus.busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 10'd0) begin
            errors++; $display("FAIL midrst async_clear: got %h expected 000", all_outs());
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            #1;
            checks++;
            if ({bus.res_valid, bus.busy} !== 2'b00) begin
                errors++; $display("FAIL midrst no_result%0d: got %b expected 00", k, {bus.res_valid, bus.busy});
            end
            tick();
        end
        test_single(1'b1, 8'h0F, 3'd0, "midrst_fresh");
    endtask

`ifdef MOD5_ARB_TIMEOUT_EN
    // TIMEOUT=4: req0 sends 0x03 with last=0 then goes silent.
    task automatic test_timeout();
        tick();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h03; bus.req0_last = 1'b0;
        tick();
        bus.req0_valid = 1'b0;
        for (int k = 0; k < W; k++) tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({bus.busy, bus.res_valid, bus.req0_ready} !== 3'b101) begin
                errors++; $display("FAIL timeout wait%0d: got %b expected 101", k, {bus.busy, bus.res_valid, bus.req0_ready});
            end
            tick();
        end
        #1;
        checks++;
        if ({bus.res_valid, bus.res_abort, bus.res_id, bus.res_residue, bus.res_divisible} !== {1'b1, 1'b1, 1'b0, 3'd3, 1'b0}) begin
            errors++; $display("FAIL timeout result: got v%b a%b id%b r%0d d%b expected v1 a1 id0 r3 d0",
                               bus.res_valid, bus.res_abort, bus.res_id, bus.res_residue, bus.res_divisible);
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL timeout after: got %b expected 00", {bus.res_valid, bus.busy});
        end
        bus.req0_valid = 1'b1; bus.req0_last = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_last = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
            errors++; $display("FAIL timeout pointer: got %b expected 01", {bus.req0_ready, bus.req1_ready});
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single(1'b0, 8'h0A, 3'd0, "single_req0");
        test_single(1'b1, 8'h07, 3'd2, "single_req1");
        test_two_word();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef MOD5_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod5_stream_arbiter.md
# mod5_stream_arbiter

Shares one serial divide-by-five residue engine between two word-oriented requesters. Each requester submits a frame: one or more WORD_W-bit words with the most significant word first, and a last flag on the final word. The arbiter grants whole frames round-robin and serialises each word MSB-first through the residue recurrence. At frame end it returns the residue mod 5 and a divisible flag, tagged with the requester id. It sits between the host-side input ports and the result consumer, in place of a per-requester serial checker.

## Interface
- WORD_W, default 8: width of one submitted word, in bits; range 2–16.
- TIMEOUT, default 255: number of idle mid-frame cycles before a frame is aborted; range 1–255. Used only with MOD5_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req0_valid  input  1  requester 0 presents a word.
- req0_data  input  WORD_W  requester 0 word, MSB first in time.
- req0_last  input  1  this word ends requester 0's frame.
- req0_ready  output  1  requester 0 word accepted this cycle when it is high together with req0_valid.
- req1_valid, req1_data, req1_last, req1_ready: same as the req0 ports, for requester 1.
- res_valid  output  1  one-cycle result strobe.
- res_id  output  1  requester that owned the finished frame.
- res_residue  output  3  frame value mod 5, range 0–4.
- res_divisible  output  1  high when res_residue is 0.
- res_abort  output  1  frame ended by timeout; always 0 unless MOD5_ARB_TIMEOUT_EN is defined.
- busy  output  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: grant decision is made here. If exactly one requester has valid high, that requester is chosen. If both are valid, the requester named by the round-robin pointer wins. Only the chosen requester's ready is driven high; it is combinational from state, the valids and the pointer. On acceptance: load the word into the shift register, clear the residue to 0, latch the owner and its last flag, then go to SHIFT.
  - SHIFT: lasts exactly WORD_W cycles. Each cycle consumes the shift register MSB and updates r <= (2r + b) mod 5, where r is the 3-bit residue and b is the consumed bit. The update uses a small case table; no divider. Both readies are 0. After the final bit, go to DONE if the latched last flag is 1, otherwise to WAIT.
  - WAIT: only the owner's ready is high. The non-owner's ready is held at 0 even if it is valid. On acceptance, load the word (the residue is kept) and go to SHIFT.
  - DONE: for one cycle, drive res_valid=1 with res_id, res_residue, res_divisible and res_abort. Flip the pointer so it favours the requester that did not own this frame. Go to IDLE.
- res_* outputs are registered. Outside DONE, res_valid is 0. res_id, res_residue and res_divisible hold their last values between strobes.
- A frame cannot be empty: the first accepted word always begins the frame.
- Data is sampled only on the acceptance edge. Changes on req*_data at any other time are ignored.

## Timing
- Reset (asynchronous, mid-frame included): state goes to IDLE and the pointer to requester 0. Residue, shift register and timeout counter go to 0. res_valid, res_id, res_residue, res_divisible, res_abort and busy all go to 0, and both readies go to 0 while rst_n is low. Any in-flight frame is discarded with no result.
- Acceptance happens at edge T. The SHIFT cycles are T+1 … T+WORD_W.
  - For a last word, res_valid is high in cycle T+WORD_W+1.
  - Otherwise ready is high again from cycle T+WORD_W+1.
- Maximum throughput is one word per WORD_W+1 cycles. A requester holding valid continuously sees back-to-back frames only if the other requester is idle.
- A requester that is valid in DONE is not accepted until the following IDLE cycle.

## Configuration
- MOD5_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle in which the owner's valid is low.
  - When the counter reaches TIMEOUT, go to DONE with res_abort=1 and res_residue set to the partial residue.
  - The pointer flips as normal.
- Not defined: the counter is not built, res_abort is tied to 0, and WAIT waits indefinitely.

## Test plan
- From reset, req0 sends 8'h0A with last=1 at edge T → res_valid at T+9 with res_id=0, residue 0, divisible 1; busy 1 from T+1 to T+9.
- req1 sends 8'h07 with last=1 → res_id=1, residue 2, divisible 0; req0_ready stays 0 throughout.
- req0 sends the two-word frame 8'h01 (last=0) then 8'h00 (last=1), value 256 → residue 1. Check that req0_ready is high during WAIT only.
- Both requesters hold valid from reset with single-word frames 8'h05 and 8'h03 → results come out as id0 (residue 0) then id1 (residue 3). Check that req1_ready never rises while req0 owns the frame.
- Assert rst_n low during SHIFT of req0's word 8'hFF → all outputs are 0 immediately and no res_valid follows. Then req1 sends 8'h0F → residue 0 (fresh start).
- With MOD5_ARB_TIMEOUT_EN and TIMEOUT=4: req0 sends 8'h03 (last=0) and then drops valid → after 4 WAIT cycles, one res_valid with res_abort=1, residue 3, and the pointer now favours req1.
